// File: rtl/ysyx_22040386_core_seq_pkg.sv
// Shared definitions for the NPC multi-cycle control sequencer.
package ysyx_22040386_core_seq_pkg;

  typedef enum logic [3:0] {
    ST_FETCH_REQ  = 4'd0,
    ST_FETCH_WAIT = 4'd1,
    ST_DECODE     = 4'd2,
    ST_EXEC       = 4'd3,
    ST_MEM_REQ    = 4'd4,
    ST_MEM_WAIT   = 4'd5,
    ST_WB         = 4'd6,
    ST_HALT       = 4'd7,
    ST_ERROR      = 4'd8
  } state_t;

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  // True for opcodes that need a load/store phase
  function automatic logic is_ls_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/ysyx_22040386_mem_timer.sv
// Saturating wait counter; flags expiry on the cycle the limit is reached.
module ysyx_22040386_mem_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = 8;
  localparam logic [W-1:0] MAX  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;
  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (enable && (count != MAX)) begin
      count_nxt = count + 1'b1;
    end
  end

  // expired means one more idle cycle will hit the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_nxt;
      expired <= (count_nxt >= LAST);
    end
  end

endmodule

// File: rtl/ysyx_22040386_core_seq.sv
// Multi-cycle NPC sequencer: fetch, decode, execute, memory, write-back.
module ysyx_22040386_core_seq
  import ysyx_22040386_core_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic [31:0] inst,
  input  logic        dec_regwrite,
  input  logic        dec_memwrite,
  input  logic        dec_memread,
  input  logic        dec_branch,
  output logic        ls_req_valid,
  output logic        ls_req_we,
  input  logic        ls_req_ready,
  input  logic        ls_rsp_valid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel_branch,
  output logic [63:0] pc_init,
  output logic [63:0] instret,
  output logic        halted,
  output logic        err,
  output logic [3:0]  state_dbg
);

  state_t state;
  logic   mem_op;
  logic   timer_clear;
  logic   timer_en;
  logic   timer_expired;

  assign mem_op      = dec_memread || dec_memwrite;
  assign timer_clear = (state == ST_WB) || ((state == ST_EXEC) && mem_op);

  // Count only cycles where the awaited handshake event is missing
  always_comb begin
    timer_en = 1'b0;
    case (state)
      ST_FETCH_REQ:  timer_en = !if_req_ready;
      ST_FETCH_WAIT: timer_en = !if_rsp_valid;
      ST_MEM_REQ:    timer_en = !ls_req_ready;
      ST_MEM_WAIT:   timer_en = !ls_rsp_valid;
      default:       timer_en = 1'b0;
    endcase
  end

  ysyx_22040386_mem_timer #(
    .LIMIT (TIMEOUT)
  ) u_mem_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH_REQ;
      inst    <= '0;
      instret <= '0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH_REQ: begin
          if (if_req_ready) begin
            if (if_rsp_valid) begin
              inst  <= if_rsp_data;
              state <= ST_DECODE;
            end else begin
              state <= ST_FETCH_WAIT;
            end
          end else if (timer_expired) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end
        end
        ST_FETCH_WAIT: begin
          if (if_rsp_valid) begin
            inst  <= if_rsp_data;
            state <= ST_DECODE;
          end else if (timer_expired) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (inst == EBREAK) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= mem_op ? ST_MEM_REQ : ST_WB;
        end
        ST_MEM_REQ: begin
          if (ls_req_ready) begin
            state <= ls_rsp_valid ? ST_WB : ST_MEM_WAIT;
          end else if (timer_expired) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (ls_rsp_valid) begin
            state <= ST_WB;
          end else if (timer_expired) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end
        end
        ST_WB: begin
          instret <= instret + 64'd1;
          state   <= ST_FETCH_REQ;
        end
        ST_HALT, ST_ERROR: begin
          state <= state;
        end
        default: begin
          state <= ST_ERROR;
          err   <= 1'b1;
        end
      endcase
    end
  end

  // Strobes decode from the state register and are forced low during reset
  assign if_req_valid  = !rst && (state == ST_FETCH_REQ);
  assign ls_req_valid  = !rst && (state == ST_MEM_REQ);
  assign ls_req_we     = ls_req_valid && dec_memwrite;
  assign pc_we         = !rst && (state == ST_WB);
  assign rf_we         = pc_we && (dec_regwrite || dec_memread);
  assign pc_sel_branch = pc_we && dec_branch;
  assign pc_init       = RESET_PC;
  assign state_dbg     = state;

endmodule

// File: tb/tb_ysyx_22040386_core_seq.sv
// Randomized scoreboard bench for the NPC control sequencer.
module tb_ysyx_22040386_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid;
  logic        if_req_ready = 1'b0;
  logic        if_rsp_valid = 1'b0;
  logic [31:0] if_rsp_data = 32'h0;
  logic [31:0] inst;
  logic        dec_regwrite, dec_memwrite, dec_memread, dec_branch;
  logic        ls_req_valid, ls_req_we;
  logic        ls_req_ready = 1'b0;
  logic        ls_rsp_valid = 1'b0;
  logic        rf_we, pc_we, pc_sel_branch;
  logic [63:0] pc_init, instret;
  logic        halted, err;
  logic [3:0]  state_dbg;

  typedef struct {
    logic        rf;
    logic        br;
    logic        store;
    int          lat;
    logic [63:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [63:0] retired = 64'd0;

  int mon_cyc = 0;
  int mon_start = 0;
  bit mon_busy = 1'b0;
  bit mon_ls_seen = 1'b0;

  ysyx_22040386_core_seq dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .inst          (inst),
    .dec_regwrite  (dec_regwrite),
    .dec_memwrite  (dec_memwrite),
    .dec_memread   (dec_memread),
    .dec_branch    (dec_branch),
    .ls_req_valid  (ls_req_valid),
    .ls_req_we     (ls_req_we),
    .ls_req_ready  (ls_req_ready),
    .ls_rsp_valid  (ls_rsp_valid),
    .rf_we         (rf_we),
    .pc_we         (pc_we),
    .pc_sel_branch (pc_sel_branch),
    .pc_init       (pc_init),
    .instret       (instret),
    .halted        (halted),
    .err           (err),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // Stand-in for the RV64 decoder, driven from the latched instruction
  always_comb begin
    dec_regwrite = 1'b0;
    dec_memwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_branch   = 1'b0;
    case (inst[6:0])
      7'b0010011, 7'b0110011: dec_regwrite = 1'b1;
      7'b0000011: begin dec_regwrite = 1'b1; dec_memread = 1'b1; end
      7'b0100011: dec_memwrite = 1'b1;
      7'b1101111, 7'b1100111: begin dec_regwrite = 1'b1; dec_branch = 1'b1; end
      7'b1100011: dec_branch = 1'b1;
      default: dec_branch = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Classes: 0 addi, 1 add, 2 ld, 3 sd, 4 jal, 5 beq
  function automatic logic [6:0] op_of(input int k);
    case (k)
      0: return 7'b0010011;
      1: return 7'b0110011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1101111;
      default: return 7'b1100011;
    endcase
  endfunction

  function automatic exp_t make_exp(input int k, input int fr, input int fs,
                                    input int lr, input int ls, input logic [63:0] ir);
    exp_t e;
    e.rf    = (k == 0) || (k == 1) || (k == 2) || (k == 4);
    e.br    = (k == 4) || (k == 5);
    e.store = (k == 3);
    e.lat   = (fr + 1 + fs) + 3 + (((k == 2) || (k == 3)) ? (lr + 1 + ls) : 0);
    e.ir    = ir;
    return e;
  endfunction

  // One request/response exchange; rsp < 0 means the response never comes
  task automatic drive_hs(input bit ls, input int rdy, input int rsp, input logic [31:0] data);
    int n = 0;
    while (!(ls ? ls_req_valid : if_req_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(ls ? ls_req_valid : if_req_valid)) begin
      note_fail(ls ? "ls_req_wait" : "if_req_wait");
      return;
    end
    repeat (rdy) @(negedge clk);
    if (ls) ls_req_ready = 1'b1; else if_req_ready = 1'b1;
    if (rsp == 0) begin
      if (ls) ls_rsp_valid = 1'b1;
      else begin if_rsp_valid = 1'b1; if_rsp_data = data; end
    end
    @(negedge clk);
    ls_req_ready = 1'b0; if_req_ready = 1'b0;
    ls_rsp_valid = 1'b0; if_rsp_valid = 1'b0;
    if (rsp > 0) begin
      repeat (rsp - 1) @(negedge clk);
      if (ls) ls_rsp_valid = 1'b1;
      else begin if_rsp_valid = 1'b1; if_rsp_data = data; end
      @(negedge clk);
      ls_rsp_valid = 1'b0; if_rsp_valid = 1'b0;
    end
  endtask

  task automatic run_instr(input int k, input int fr, input int fs, input int lr, input int ls);
    logic [31:0] r;
    r = $urandom;
    exp_q.push_back(make_exp(k, fr, fs, lr, ls, retired));
    drive_hs(1'b0, fr, fs, {r[31:7], op_of(k)});
    if ((k == 2) || (k == 3)) drive_hs(1'b1, lr, ls, 32'h0);
    retired++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_req_ready = 1'b0; if_rsp_valid = 1'b0;
    ls_req_ready = 1'b0; ls_rsp_valid = 1'b0;
    exp_q.delete();
    retired = 64'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_strobes", 64'({if_req_valid, ls_req_valid, rf_we, pc_we}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_flags_inst", 64'({halted, err, inst}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every write-back strobe
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (rst) begin
        mon_busy = 1'b0;
        mon_ls_seen = 1'b0;
      end else begin
        if (if_req_valid && !mon_busy) begin
          mon_busy = 1'b1;
          mon_start = mon_cyc;
          mon_ls_seen = 1'b0;
        end
        if (ls_req_valid && !mon_ls_seen) begin
          mon_ls_seen = 1'b1;
          if (exp_q.size() > 0) check("ls_req_we", 64'(ls_req_we), 64'(exp_q[0].store));
          else note_fail("ls_req_no_instr");
        end
        if ((rf_we || pc_sel_branch) && !pc_we) note_fail("strobe_outside_wb");
        if (pc_we) begin
          if (exp_q.size() == 0) begin
            note_fail("wb_no_instr");
          end else begin
            e = exp_q.pop_front();
            check("wb_rf_we", 64'(rf_we), 64'(e.rf));
            check("wb_pc_sel", 64'(pc_sel_branch), 64'(e.br));
            check("wb_instret", instret, e.ir);
            check("wb_latency", 64'(mon_cyc - mon_start + 1), 64'(e.lat));
            check("wb_state", 64'(state_dbg), 64'd6);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int viol;
    int cnt;
    do_reset();
    check("pc_init", pc_init, 64'h8000_0000);

    run_instr(0, 0, 0, 0, 0);
    run_instr(3, 0, 3, 2, 0);
    run_instr(4, 0, 0, 0, 0);
    run_instr(2, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    cnt = 0;
    while (!if_req_valid && cnt < 20) begin @(negedge clk); cnt++; end
    check("instret_total", instret, retired);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // ebreak parks the core
    drive_hs(1'b0, 0, 0, 32'h0010_0073);
    @(negedge clk);
    check("halt_state", 64'(state_dbg), 64'd7);
    viol = 0;
    if_req_ready = 1'b1; if_rsp_valid = 1'b1; ls_rsp_valid = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!halted || err || state_dbg != 4'd7 ||
          if_req_valid || ls_req_valid || rf_we || pc_we) viol++;
    end
    if_req_ready = 1'b0; if_rsp_valid = 1'b0; ls_rsp_valid = 1'b0;
    check("halt_hold", 64'(viol), 64'd0);
    check("halt_instret", instret, retired);

    // Load response never arrives
    do_reset();
    exp_q.push_back(make_exp(2, 0, 0, 0, 0, retired));
    drive_hs(1'b0, 0, 0, {25'h0, 7'b0000011});
    drive_hs(1'b1, 0, -1, 32'h0);
    cnt = 0;
    while (state_dbg == 4'd5 && cnt < 400) begin cnt++; @(negedge clk); end
    check("timeout_cycles", 64'(cnt), 64'd255);
    check("timeout_state", 64'(state_dbg), 64'd8);
    check("timeout_err", 64'({err, halted}), 64'b10);
    viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (!err || state_dbg != 4'd8 || if_req_valid || ls_req_valid || rf_we || pc_we) viol++;
    end
    check("error_hold", 64'(viol), 64'd0);
    check("error_instret", instret, 64'd0);

    // Reset in MEM_WAIT, then a stale load response
    do_reset();
    exp_q.push_back(make_exp(2, 0, 0, 0, 0, retired));
    drive_hs(1'b0, 0, 0, {25'h0, 7'b0000011});
    drive_hs(1'b1, 0, -1, 32'h0);
    repeat (3) @(negedge clk);
    check("pre_rst_mem_wait", 64'(state_dbg), 64'd5);
    do_reset();
    ls_rsp_valid = 1'b1;
    @(negedge clk);
    ls_rsp_valid = 1'b0;
    viol = 0;
    repeat (4) begin
      @(negedge clk);
      if (rf_we || pc_we || state_dbg != 4'd0) viol++;
    end
    check("late_rsp_ignored", 64'(viol), 64'd0);
    check("late_rsp_instret", instret, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
